// File: rtl/shiftreg_spi_ctrl.sv
// shiftreg_spi_ctrl
//   Serialises a parallel routing word into the switch-matrix shift-register
//   chain. The word is sent MSB first on spi_mosi_o, clocked by spi_clk_o at
//   clk/(2*CLK_DIV). After the last bit, spi_latch_o pulses to commit the word.
//
// Parameters
//   N        bits per transfer (chain length), N >= 2
//   CLK_DIV  clk cycles per spi_clk half-period, CLK_DIV >= 1
//
// Ports
//   clk_i        system clock, posedge
//   reset_i      asynchronous active-high reset
//   tx_data_i    word to send; bit N-1 goes out first
//   tx_valid_i   tx_data_i valid; accepted when tx_valid_i & tx_ready_o
//   tx_ready_o   controller idle
//   busy_o       transfer in progress (always ~tx_ready_o)
//   spi_clk_o    serial clock, idle low; the chain samples on its rising edge
//   spi_mosi_o   serial data; changes only while spi_clk_o is low
//   spi_latch_o  high for CLK_DIV cycles after the last bit
//
// Optional readback (macro SHIFTREG_READBACK_EN)
//   spi_miso_i   chain output, sampled at the end of each spi_clk high phase
//   rx_data_o    word read back from the chain, updated as spi_latch_o rises
//   rx_valid_o   one-cycle strobe that accompanies a new rx_data_o
module shiftreg_spi_ctrl #(
  parameter int N       = 8,
  parameter int CLK_DIV = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] tx_data_i,
  input  logic         tx_valid_i,
  output logic         tx_ready_o,
  output logic         busy_o,
  output logic         spi_clk_o,
  output logic         spi_mosi_o,
`ifdef SHIFTREG_READBACK_EN
  input  logic         spi_miso_i,
  output logic [N-1:0] rx_data_o,
  output logic         rx_valid_o,
`endif
  output logic         spi_latch_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [N-1:0]   shreg_q, shreg_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           sclk_q, sclk_d;
  logic           mosi_q, mosi_d;
  logic           latch_q, latch_d;
  logic           div_last;

`ifdef SHIFTREG_READBACK_EN
  logic [N-1:0]   rx_shreg_q, rx_shreg_d;
  logic [N-1:0]   rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
`endif

  assign div_last = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    latch_d = latch_q;
`ifdef SHIFTREG_READBACK_EN
    rx_shreg_d = rx_shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (tx_valid_i && ready_q) begin
          shreg_d = tx_data_i;
          mosi_d  = tx_data_i[N-1];
          bit_d   = BW'(N - 1);
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (div_last) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      HIGH: begin
        if (div_last) begin
          div_d  = '0;
          sclk_d = 1'b0;
`ifdef SHIFTREG_READBACK_EN
          rx_shreg_d = {rx_shreg_q[N-2:0], spi_miso_i};
`endif
          if (bit_q != '0) begin
            // mosi already holds the current MSB, so the next bit is N-2
            shreg_d = shreg_q << 1;
            mosi_d  = shreg_q[N-2];
            bit_d   = bit_q - BW'(1);
            state_d = LOW;
          end else begin
            mosi_d  = 1'b0;
            latch_d = 1'b1;
            state_d = LATCH;
`ifdef SHIFTREG_READBACK_EN
            // include the bit captured on this very edge
            rx_data_d  = {rx_shreg_q[N-2:0], spi_miso_i};
            rx_valid_d = 1'b1;
`endif
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      LATCH: begin
        if (div_last) begin
          div_d   = '0;
          latch_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      latch_q <= latch_d;
    end
  end

`ifdef SHIFTREG_READBACK_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_shreg_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_shreg_q <= rx_shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
`endif

  assign tx_ready_o  = ready_q;
  assign busy_o      = busy_q;
  assign spi_clk_o   = sclk_q;
  assign spi_mosi_o  = mosi_q;
  assign spi_latch_o = latch_q;

endmodule

// File: tb/tb_shiftreg_spi_ctrl.sv
// Bench for shiftreg_spi_ctrl: instance 0 uses CLK_DIV=2, instance 1 uses
// CLK_DIV=1, both N=8. Each drives an 8-bit shift-register chain model
// (plus one output stage feeding spi_miso when readback is built in).
module tb_shiftreg_spi_ctrl;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst[2];
  logic [7:0] txd[2];
  logic       txv[2];
  logic       rdy[2], bsy[2], sclk[2], mosi[2], lat[2];

  int passed = 0, total = 0;

  // chain model state
  logic [8:0] sr[2]      = '{default: '0};
  logic       sclk_p[2]  = '{default: 1'b0};
  logic       lat_p[2]   = '{default: 1'b0};
  int         rises[2]   = '{default: 0};
  int         toggles[2] = '{default: 0};
  int         latcyc[2]  = '{default: 0};
  int         pulses[2]  = '{default: 0};
  logic [7:0] word[2]    = '{default: '0};

  always #5 clk = ~clk;

`ifdef SHIFTREG_READBACK_EN
  logic       miso;
  logic [7:0] rxd0, rxd1;
  logic       rxv0, rxv1, rxv0_p = 1'b0;
  int         rxpulses = 0;
  assign miso = sr[0][8];
  always @(negedge clk) begin
    rxv0_p <= rxv0;
    if (rxv0 && !rxv0_p) rxpulses <= rxpulses + 1;
  end
`endif

  shiftreg_spi_ctrl #(.N(N), .CLK_DIV(2)) dut0 (
    .clk_i(clk), .reset_i(rst[0]), .tx_data_i(txd[0]), .tx_valid_i(txv[0]),
    .tx_ready_o(rdy[0]), .busy_o(bsy[0]), .spi_clk_o(sclk[0]), .spi_mosi_o(mosi[0]),
`ifdef SHIFTREG_READBACK_EN
    .spi_miso_i(miso), .rx_data_o(rxd0), .rx_valid_o(rxv0),
`endif
    .spi_latch_o(lat[0]));

  shiftreg_spi_ctrl #(.N(N), .CLK_DIV(1)) dut1 (
    .clk_i(clk), .reset_i(rst[1]), .tx_data_i(txd[1]), .tx_valid_i(txv[1]),
    .tx_ready_o(rdy[1]), .busy_o(bsy[1]), .spi_clk_o(sclk[1]), .spi_mosi_o(mosi[1]),
`ifdef SHIFTREG_READBACK_EN
    .spi_miso_i(1'b0), .rx_data_o(rxd1), .rx_valid_o(rxv1),
`endif
    .spi_latch_o(lat[1]));

  // Chain model: shift on each rising spi_clk, commit on rising spi_latch.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      sclk_p[k] <= sclk[k];
      lat_p[k]  <= lat[k];
      if (sclk[k] && !sclk_p[k]) begin
        sr[k]    <= {sr[k][7:0], mosi[k]};
        rises[k] <= rises[k] + 1;
      end
      if (sclk[k] !== sclk_p[k]) toggles[k] <= toggles[k] + 1;
      if (lat[k]) latcyc[k] <= latcyc[k] + 1;
      if (lat[k] && !lat_p[k]) begin
        pulses[k] <= pulses[k] + 1;
        word[k]   <= sr[k][7:0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one word into an idle instance and count cycles until tx_ready returns.
  task automatic xfer(input int k, input logic [7:0] w, output int bc);
    @(negedge clk);
    txd[k] = w;
    txv[k] = 1'b1;
    @(posedge clk);
    #1 txv[k] = 1'b0;
    bc = 0;
    while (!rdy[k] && bc < 1000) begin
      @(posedge clk);
      #1 bc++;
    end
  endtask

  // Reference: the chain must hold the word, N rising edges, latch high for
  // CLK_DIV cycles, tx_ready low for (2N+1)*CLK_DIV cycles.
  task automatic send_check(input int k, input int cdiv, input logic [7:0] w, input string tag);
    int bc, r0, l0, p0, t0;
    r0 = rises[k]; l0 = latcyc[k]; p0 = pulses[k]; t0 = toggles[k];
    xfer(k, w, bc);
    @(negedge clk);
    chk({tag, "_word"},   word[k], w);
    chk({tag, "_rises"},  rises[k] - r0, N);
    chk({tag, "_latcyc"}, latcyc[k] - l0, cdiv);
    chk({tag, "_pulses"}, pulses[k] - p0, 1);
    chk({tag, "_busy"},   bc, (2 * N + 1) * cdiv);
    if (cdiv == 1) chk({tag, "_toggles"}, toggles[k] - t0, 2 * N);
  endtask

  initial begin
    int bc, r0, p0, n;
    logic [7:0] w;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; txd[k] = '0; txv[k] = 1'b0;
    end
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", rdy[k], 1'b1);
      chk("rst_busy",  bsy[k], 1'b0);
      chk("rst_sclk",  sclk[k], 1'b0);
      chk("rst_mosi",  mosi[k], 1'b0);
      chk("rst_latch", lat[k], 1'b0);
    end
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (2) @(posedge clk);

    // basic transfer
    send_check(0, 2, 8'hA5, "a5");

    // tx_valid held high: two back-to-back words, data changed right after accept
    p0 = pulses[0];
    @(negedge clk);
    txd[0] = 8'h3C; txv[0] = 1'b1;
    @(posedge clk);
    #1 txd[0] = 8'hC3;
    chk("b2b_busy_flag", bsy[0], 1'b1);
    bc = 0;
    while (!rdy[0] && bc < 1000) begin @(posedge clk); #1 bc++; end
    chk("b2b_busy1", bc, 34);
    chk("b2b_word1", word[0], 8'h3C);
    @(posedge clk);
    #1 txv[0] = 1'b0;
    chk("b2b_accept2", rdy[0], 1'b0);
    bc = 0;
    while (!rdy[0] && bc < 1000) begin @(posedge clk); #1 bc++; end
    chk("b2b_busy2", bc, 34);
    @(negedge clk);
    chk("b2b_word2", word[0], 8'hC3);
    chk("b2b_pulses", pulses[0] - p0, 2);

    // tx_valid pulse while busy is ignored
    p0 = pulses[0];
    @(negedge clk);
    txd[0] = 8'h00; txv[0] = 1'b1;
    @(posedge clk);
    #1 txv[0] = 1'b0;
    bc = 0;
    while (!rdy[0] && bc < 1000) begin
      @(posedge clk);
      #1 bc++;
      if (bc == 5) begin txd[0] = 8'hFF; txv[0] = 1'b1; end
      if (bc == 6) txv[0] = 1'b0;
    end
    chk("ign_busy", bc, 34);
    r0 = rises[0];
    repeat (10) @(posedge clk);
    #1;
    chk("ign_idle", rdy[0], 1'b1);
    chk("ign_word", word[0], 8'h00);
    chk("ign_norises", rises[0] - r0, 0);
    chk("ign_pulses", pulses[0] - p0, 1);

    // randomized words on both instances
    for (int i = 0; i < 5; i++) begin
      w = 8'($urandom_range(0, 255));
      send_check(0, 2, w, "rnd0");
    end
    send_check(1, 1, 8'h5A, "div1_5a");
    for (int i = 0; i < 3; i++) begin
      w = 8'($urandom_range(0, 255));
      send_check(1, 1, w, "rnd1");
    end

    // reset in the middle of a transfer
    p0 = pulses[0];
    r0 = rises[0];
    @(negedge clk);
    txd[0] = 8'hF0; txv[0] = 1'b1;
    @(posedge clk);
    #1 txv[0] = 1'b0;
    n = 0;
    while (rises[0] - r0 < 3 && n < 500) begin @(posedge clk); n++; end
    chk("mid_rises3", (rises[0] - r0 >= 3), 1'b1);
    #1 rst[0] = 1'b1;
    #1;
    chk("mid_sclk",  sclk[0], 1'b0);
    chk("mid_latch", lat[0], 1'b0);
    chk("mid_ready", rdy[0], 1'b1);
    chk("mid_busy",  bsy[0], 1'b0);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (40) @(posedge clk);
    chk("mid_nolatch", pulses[0] - p0, 0);
    send_check(0, 2, 8'h81, "after_rst");

`ifdef SHIFTREG_READBACK_EN
    // chain output loops back: each transfer reads the previous word
    p0 = rxpulses;
    send_check(0, 2, 8'hA5, "rb_a5");
    chk("rb_rx1", rxd0, 8'h81);
    chk("rb_rxv1", rxpulses - p0, 1);
    send_check(0, 2, 8'h0F, "rb_0f");
    chk("rb_rx2", rxd0, 8'hA5);
    chk("rb_rxv2", rxpulses - p0, 2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
